uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
// Serial UART transmitter: accepts a byte over a valid/ready handshake and
// shifts it out on tx as a standard 8N1-style asynchronous frame (start bit,
// DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits).
// Sits between the byte-producing logic and the board TX pin; the frame it
// produces is the one the UART receiver decodes. Baud timing comes from an
// internal divider on sck, so no separate baud clock is needed.
//
// PARAMETERS
// CLK_DIV    434  sck cycles per serial bit (>=2); 50 MHz / 115200 baud
// DATA_BITS  8    data bits per frame (5..8)
// PARITY     0    0 = none, 1 = even, 2 = odd
// STOP_BITS  1    stop bits per frame (1 or 2)
//
// PORTS
// sck    in   1          system clock; all logic on posedge sck
// reset  in   1          synchronous, active-high reset
// data   in   DATA_BITS  byte to send; sampled only on an accept cycle
// valid  in   1          producer has data; must hold data stable until accepted
// ready  out  1          transmitter can accept; accept = valid & ready
// tx     out  1          serial line, idle high; registered output
// busy   out  1          high from the cycle after accept through the last stop cycle
//
// BEHAVIOUR
// - Reset (sampled at posedge sck): state=IDLE, tx=1, busy=0, divider=0,
//   bit index=0. ready = (state==IDLE) & ~reset, so it is low while reset is
//   high and high on the first cycle after reset deasserts.
// - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   tx=1. On accept, latch data into the shift register and enter START.
//   START:  tx=0 for CLK_DIV cycles, then DATA with bit index 0.
//   DATA:   tx = shift[0] for CLK_DIV cycles per bit; shift right; after bit
//           DATA_BITS-1 go to PARITY if PARITY!=0, otherwise to STOP.
//   PARITY: tx = XOR of the latched data bits (PARITY=1) or its inverse
//           (PARITY=2), for CLK_DIV cycles.
//   STOP:   tx=1 for STOP_BITS*CLK_DIV cycles, then IDLE.
// - Divider: counts 0..CLK_DIV-1. It resets to 0 on every state or bit change,
//   so each bit lasts exactly CLK_DIV cycles and there is no cumulative drift.
// - Latency: tx falls on the first posedge after the accept edge (one cycle).
//   Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles.
// - Back-to-back frames: ready is high in the IDLE cycle after STOP. If valid
//   is held, the next frame is accepted in that cycle, which gives exactly one
//   extra idle-high cycle between frames. Transmit throughput is never below
//   one frame per (frame length + 1) cycles.
// - ready is low in all non-IDLE states. valid and data are ignored there,
//   and changing data mid-frame has no effect on the frame in flight.
// - Reset mid-frame: aborts the frame immediately, so tx returns high on the
//   next edge. A truncated frame on the line is acceptable.
// - Illegal or unreachable state encodings return to IDLE with tx=1.
//
// TESTING (bench uses CLK_DIV=4, DATA_BITS=8, STOP_BITS=1)
// 1. PARITY=0, reset, then send 0xA5 -> ready=1 the cycle after reset; tx
//    holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (40 cycles total); busy
//    high for 40 cycles; a loopback receiver captures 0xA5.
// 2. PARITY=1 send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1;
//    frame length 44 cycles. PARITY=2 with 0x07 -> parity bit 0.
// 3. valid held high with data 0x00 then 0xFF -> two frames; the tx low edge
//    of frame 2 comes exactly 41 cycles after the low edge of frame 1.
// 4. Change data and pulse valid mid-frame -> ready=0, frame unchanged,
//    no extra frame is sent.
// 5. Assert reset 10 cycles into a frame -> tx=1, busy=0 on the next edge;
//    ready=1 on the first cycle after reset is released.
// 6. STOP_BITS=2 send 0x55 -> stop level held 8 cycles; frame length 44 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: takes a word over valid/ready and shifts it out on tx as
// start bit, DATA_BITS data bits LSB first, optional parity bit and
// STOP_BITS stop bits. Bit timing comes from an internal divider on sck.
module uart_tx #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sck,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int              DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       DBIT_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       SBIT_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [DIV_W-1:0]     r_div;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 w_bit_end;

  // Last cycle of the current serial bit.
  assign w_bit_end = (r_div == DIV_LAST);

  // Accepting only in IDLE keeps data changes from touching a frame in flight.
  assign ready = (r_state == S_IDLE) & ~reset;
  assign tx    = r_tx;
  assign busy  = r_busy;

  // Frame sequencer: divider, bit index, shifter and registered line outputs.
  always_ff @(posedge sck) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_div     <= '0;
          r_bit_idx <= '0;
          if (valid) begin
            // Parity is fixed at accept so later shifting cannot disturb it.
            r_shift <= data;
            r_par   <= (^data) ^ (PARITY == 2);
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_div     <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_state   <= S_DATA;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_div <= '0;
            if (r_bit_idx == DBIT_LAST) begin
              r_bit_idx <= '0;
              if (PARITY != 0) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_div     <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_state   <= S_STOP;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_STOP: begin
          // Bit index counts stop bits here; divider still restarts per bit.
          if (w_bit_end) begin
            r_div <= '0;
            if (r_bit_idx == SBIT_LAST) begin
              r_bit_idx <= '0;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_div     <= '0;
          r_bit_idx <= '0;
          r_tx      <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (parity none/even/odd, one or two stop
// bits) each with a driver pushing expected frames into a queue and a
// monitor that matches the line waveform cycle by cycle.
module tb_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int NLANE   = 4;

  logic sck = 1'b0;
  always #5 sck = ~sck;

  int unsigned cyc = 0;
  always @(posedge sck) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  typedef struct {
    logic [7:0] d;
    bit         b2b;
  } exp_t;

  function automatic void chk(input string nm, input int lane,
                              input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d: got %0h expected %0h at cycle %0d",
               nm, lane, act, exp, cyc);
    end
  endfunction

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    localparam int P     = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int S     = (g >= 2) ? 2 : 1;
    localparam int NBITS = 1 + 8 + ((P != 0) ? 1 : 0) + S;
    localparam int FRAME = NBITS * CLK_DIV;

    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = '0;
    logic       ready, tx, busy;
    bit         abort = 1'b0;
    exp_t       q[$];

    uart_tx #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(P), .STOP_BITS(S)) u_dut (
      .sck   (sck),
      .reset (reset),
      .data  (data),
      .valid (valid),
      .ready (ready),
      .tx    (tx),
      .busy  (busy)
    );

    // Reference line levels for one frame, one entry per serial bit.
    function automatic void frame_bits(input logic [7:0] d, output logic b [0:11]);
      int k;
      for (int i = 0; i < 12; i++) b[i] = 1'b1;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[1+i] = d[i];
      k = 9;
      if (P != 0) begin
        b[k] = ($countones(d) % 2 == 1) ^ (P == 2);
        k++;
      end
    endfunction

    task automatic tick();
      @(posedge sck);
      #1;
    endtask

    // Present d, wait for acceptance and record the expected frame.
    task automatic send(input logic [7:0] d, input bit b2b);
      int n = 0;
      exp_t e;
      valid = 1'b1;
      data  = d;
      do begin
        @(negedge sck);
        n++;
      end while (!ready && n < 200);
      if (!ready) chk("accept_timeout", g, 0, 1);
      @(posedge sck);
      e.d = d;
      e.b2b = b2b;
      q.push_back(e);
      #1;
    endtask

    // Driver
    initial begin
      logic [7:0] d;
      int n;
      repeat (3) @(negedge sck);
      chk("rst_tx", g, 32'(tx), 1);
      chk("rst_busy", g, 32'(busy), 0);
      chk("rst_ready", g, 32'(ready), 0);
      tick();
      reset = 1'b0;
      @(negedge sck);
      chk("ready_after_rst", g, 32'(ready), 1);
      tick();

      send(8'hA5, 0); valid = 1'b0;
      repeat (3) tick();
      send(8'h07, 0); valid = 1'b0;

      // Held valid: second frame must follow with a single idle cycle.
      send(8'h00, 0);
      send(8'hFF, 1); valid = 1'b0;

      // Mid-frame data change and valid pulse must be ignored.
      send(8'h3C, 0); valid = 1'b0;
      repeat (5) tick();
      data  = 8'hC3;
      valid = 1'b1;
      repeat (2) begin
        @(negedge sck);
        chk("ready_midframe", g, 32'(ready), 0);
        tick();
      end
      valid = 1'b0;

      for (int i = 0; i < 16; i++) begin
        d = 8'($urandom);
        send(d, 0);
        valid = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
      end

      // Abort a frame 10 cycles in.
      send(8'h99, 0); valid = 1'b0;
      repeat (10) tick();
      abort = 1'b1;
      reset = 1'b1;
      tick();
      chk("abort_tx", g, 32'(tx), 1);
      chk("abort_busy", g, 32'(busy), 0);
      chk("abort_ready", g, 32'(ready), 0);
      reset = 1'b0;
      @(negedge sck);
      chk("ready_after_abort", g, 32'(ready), 1);
      abort = 1'b0;
      tick();

      send(8'h5A, 0); valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 500) begin
        tick();
        n++;
      end
      chk("drain", g, 32'(q.size()), 0);
      repeat (FRAME + 8) tick();
      chk("idle_ready", g, 32'(ready), 1);
      n_done++;
    end

    // Monitor: detect the start edge, then check every cycle of the frame.
    initial begin
      exp_t        e;
      logic        b [0:11];
      logic [7:0]  rx;
      bit          ok, aborted;
      int unsigned start_cyc, last_start;
      last_start = 0;
      forever begin
        @(negedge sck);
        if (!reset && !abort && tx === 1'b0) begin
          start_cyc = cyc;
          if (q.size() == 0) begin
            chk("unexpected_frame", g, 1, 0);
            while (tx !== 1'b1) @(negedge sck);
          end else begin
            e = q.pop_front();
            frame_bits(e.d, b);
            ok = 1'b1;
            aborted = 1'b0;
            rx = '0;
            for (int c = 0; c < FRAME; c++) begin
              if (c > 0) @(negedge sck);
              if (abort) begin
                aborted = 1'b1;
                break;
              end
              if (tx !== b[c / CLK_DIV] || busy !== 1'b1) begin
                ok = 1'b0;
                $display("FAIL wave lane%0d byte %0h cyc %0d: tx=%b busy=%b required tx=%b busy=1",
                         g, e.d, c, tx, busy, b[c / CLK_DIV]);
              end
              if (c % CLK_DIV == CLK_DIV / 2 && c / CLK_DIV >= 1 && c / CLK_DIV <= 8)
                rx[c / CLK_DIV - 1] = tx;
            end
            if (aborted) begin
              while (abort) @(negedge sck);
            end else begin
              @(negedge sck);
              if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
              chk("frame_wave", g, 32'(ok), 1);
              chk("loopback", g, 32'(rx), 32'(e.d));
              if (e.b2b) chk("b2b_spacing", g, start_cyc - last_start, FRAME + 1);
            end
            last_start = start_cyc;
          end
        end
      end
    end
  end

  initial begin
    fork
      begin
        wait (n_done == NLANE);
        repeat (5) @(posedge sck);
      end
      begin
        #400000;
        $display("FAIL timeout: %0d of %0d lanes finished", n_done, NLANE);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
